// File: rtl/msrv32_pkg.sv
// Shared constants for the MSRV32 core.
// PC source encodings, XLEN and the default boot vector.
package msrv32_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  localparam logic [XLEN-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/msrv32_pc.sv
// MSRV32 program-counter select stage.
// Picks the next PC and registers the AHB instruction fetch address.
module msrv32_pc
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDR_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        branch_taken_in,
  input  logic        ahb_ready_in,
  input  logic [1:0]  pc_src_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] epc_in,
  input  logic [31:0] trap_address_in,
  input  logic [31:1] iaddr_in,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] pc_mux_out,
  output logic        misaligned_instr_logic_out,
  output logic [31:0] i_addr_out
);

  logic [31:0] next_pc;

  assign pc_plus_4_out = pc_in + 32'd4;

  assign next_pc = branch_taken_in ? {iaddr_in, 1'b0}
                                   : pc_plus_4_out;

  // Flag reflects the branch target even when a trap overrides it
  assign misaligned_instr_logic_out =
    branch_taken_in & next_pc[1];

  always_comb begin
    pc_mux_out = next_pc;
    unique case (pc_src_in)
      PC_BOOT: pc_mux_out = BOOT_ADDRESS;
      PC_EPC:  pc_mux_out = epc_in;
      PC_TRAP: pc_mux_out = trap_address_in;
      PC_NEXT: pc_mux_out = next_pc;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in)
      i_addr_out <= BOOT_ADDRESS;
    else if (ahb_ready_in)
      i_addr_out <= pc_mux_out;
    else
      i_addr_out <= pc_in;
  end

endmodule

// File: tb/tb_msrv32_pc.sv
// Testbench for msrv32_pc.
// Behavioural model plus directed literal checks.
module tb_msrv32_pc;

  logic        clk;
  logic        rst;
  logic        bt;
  logic        ready;
  logic [1:0]  src;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] trap;
  logic [31:1] iaddr;
  logic [31:0] plus4;
  logic [31:0] mux;
  logic        mis;
  logic [31:0] iad;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  msrv32_pc #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_in                     (clk),
    .rst_in                     (rst),
    .branch_taken_in            (bt),
    .ahb_ready_in               (ready),
    .pc_src_in                  (src),
    .pc_in                      (pc),
    .epc_in                     (epc),
    .trap_address_in            (trap),
    .iaddr_in                   (iaddr),
    .pc_plus_4_out              (plus4),
    .pc_mux_out                 (mux),
    .misaligned_instr_logic_out (mis),
    .i_addr_out                 (iad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: plain arithmetic over the candidate list
  function automatic logic [31:0] m_target();
    return {iaddr, 1'b0};
  endfunction

  function automatic logic [31:0] m_plus4();
    return 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
  endfunction

  function automatic logic [31:0] m_mux();
    logic [31:0] cand [4];
    cand[0] = BOOT;
    cand[1] = epc;
    cand[2] = trap;
    cand[3] = bt ? m_target() : m_plus4();
    return cand[src];
  endfunction

  function automatic logic m_mis();
    return bt && (m_target() % 4 != 0);
  endfunction

  logic [31:0] m_iad;
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst)       m_iad <= BOOT;
    else if (ready) m_iad <= m_mux();
    else            m_iad <= pc;
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    chk("m_plus4", plus4, m_plus4());
    chk("m_mux", mux, m_mux());
    chk("m_mis", 32'(mis), 32'(m_mis()));
    if (m_valid) chk("m_iaddr", iad, m_iad);
  end

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] sweep [4];
    sweep[0] = 32'h0;
    sweep[1] = 32'h4;
    sweep[2] = 32'h8;
    sweep[3] = 32'h10;

    pc    = 32'h0000_000C;
    epc   = 32'h0000_0004;
    trap  = 32'h0000_0008;
    iaddr = 31'b1010110000111110011111010000101;
    rst   = 1'b0;
    bt    = 1'b0;
    ready = 1'b1;
    src   = 2'b11;

    // 1: reset
    edge_();
    chk("reset_iaddr", iad, 32'h0);
    rst = 1'b1;

    // 2: source sweep
    for (int s = 0; s < 4; s++) begin
      src = 2'(s);
      @(negedge clk);
      chk("sweep_mux", mux, sweep[s]);
      chk("sweep_plus4", plus4, 32'h10);
      chk("sweep_mis", 32'(mis), 32'h0);
      edge_();
      chk("sweep_iaddr", iad, sweep[s]);
    end

    // 3: misaligned taken branch
    bt  = 1'b1;
    src = 2'b11;
    @(negedge clk);
    chk("br_mux", mux, 32'hAC3E_7D0A);
    chk("br_mis", 32'(mis), 32'h1);
    edge_();
    chk("br_iaddr", iad, 32'hAC3E_7D0A);
    src = 2'b01;
    @(negedge clk);
    chk("br_epc_mux", mux, 32'h4);
    chk("br_epc_mis", 32'(mis), 32'h1);

    // 4: aligned target
    iaddr = 31'h80;
    src   = 2'b11;
    @(negedge clk);
    chk("al_mux", mux, 32'h100);
    chk("al_mis", 32'(mis), 32'h0);

    // 5: bus stall
    bt    = 1'b0;
    ready = 1'b0;
    src   = 2'b10;
    edge_();
    chk("stall_iaddr", iad, 32'hC);
    @(negedge clk);
    chk("stall_mux", mux, 32'h8);
    ready = 1'b1;
    edge_();
    chk("resume_iaddr", iad, 32'h8);

    // 6: wrap and reset over stall
    pc = 32'hFFFF_FFFC;
    src = 2'b11;
    @(negedge clk);
    chk("wrap_plus4", plus4, 32'h0);
    chk("wrap_mux", mux, 32'h0);
    edge_();
    chk("wrap_iaddr", iad, 32'h0);
    pc = 32'h0000_0040;
    edge_();
    chk("pre_rst_iaddr", iad, 32'h44);
    rst   = 1'b0;
    ready = 1'b0;
    edge_();
    chk("rst_stall_iaddr", iad, BOOT);

    // Reset mid-flight with a taken branch and trap pending
    rst = 1'b1;
    ready = 1'b1;
    edge_();
    chk("run_iaddr", iad, 32'h44);
    rst = 1'b0;
    bt  = 1'b1;
    src = 2'b10;
    edge_();
    chk("rst_br_iaddr", iad, BOOT);
    rst = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
